// File: rtl/ssp_uart_host_if.sv
// Request/response and SSP_UART slave bus bundle for ssp_uart_host.
// The master modport is the host side; the slave modport is the requester plus the slave.
interface ssp_uart_host_if;
    logic        Req_Valid;
    logic        Req_Ready;
    logic [2:0]  Req_RA;
    logic        Req_WnR;
    logic [11:0] Req_Data;
    logic        Abort;
    logic        Rsp_Valid;
    logic [11:0] Rsp_Data;
    logic        Rsp_Abort;
    logic        SSP_SSEL;
    logic        SSP_SCK;
    logic        SSP_WnR;
    logic        SSP_En;
    logic        SSP_EOC;
    logic [2:0]  SSP_RA;
    logic [11:0] SSP_DI;
    logic [11:0] SSP_DO;
    logic        IRQ;
    logic        Irq_Pend;
    logic        Irq_Clr;

    modport master (
        input  Req_Valid, Req_RA, Req_WnR, Req_Data, Abort, SSP_DO, IRQ, Irq_Clr,
        output Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Abort,
        output SSP_SSEL, SSP_SCK, SSP_WnR, SSP_En, SSP_EOC, SSP_RA, SSP_DI, Irq_Pend
    );

    modport slave (
        output Req_Valid, Req_RA, Req_WnR, Req_Data, Abort, SSP_DO, IRQ, Irq_Clr,
        input  Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Abort,
        input  SSP_SSEL, SSP_SCK, SSP_WnR, SSP_En, SSP_EOC, SSP_RA, SSP_DI, Irq_Pend
    );
endinterface

// File: rtl/ssp_uart_host.sv
// SSP initiator framing one register access to the SSP_UART slave (SEL/XFER/EOC/DONE).
// Optional macro SSP_UART_HOST_IRQ_SYNC_EN adds a 2-flop synchronizer on IRQ.
module ssp_uart_host #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned SETUP   = 1
) (
    input logic             Clk,
    input logic             Rst,
    ssp_uart_host_if.master bus
);

    localparam logic [7:0] HP_LOAD   = 8'(CLK_DIV - 32'd1);
    localparam logic [3:0] SU_LOAD   = 4'(SETUP - 32'd1);
    localparam logic [4:0] XFER_LAST = 5'd23;
    localparam logic [4:0] EOC_LAST  = 5'd1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_XFER = 3'd2,
        ST_EOC  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  hp_cnt_r, hp_cnt_s;
    logic [4:0]  edge_cnt_r, edge_cnt_s;
    logic [3:0]  setup_cnt_r, setup_cnt_s;
    logic        sck_r, sck_s;
    logic        accept_s, capture_s, abort_s;
    logic        ssel_r, en_r, eoc_r, ready_r;
    logic        rsp_valid_r, rsp_abort_r;
    logic [11:0] rsp_data_r;
    logic [2:0]  ra_r;
    logic        wnr_r;
    logic [11:0] di_r;
    logic        irq_set_s;
    logic        irq_pend_r;

    // Next-state, counter reloads and SCK toggling; every transition reloads the counters it uses.
    always_comb begin
        state_s     = state_r;
        hp_cnt_s    = hp_cnt_r;
        edge_cnt_s  = edge_cnt_r;
        setup_cnt_s = setup_cnt_r;
        sck_s       = sck_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sck_s = 1'b0;
                if (bus.Req_Valid) begin
                    accept_s    = 1'b1;
                    state_s     = ST_SEL;
                    setup_cnt_s = SU_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEL: begin
                if (bus.Abort) begin
                    abort_s = 1'b1;
                    state_s = ST_DONE;
                    sck_s   = 1'b0;
                end else if (setup_cnt_r == 4'd0) begin
                    state_s    = ST_XFER;
                    hp_cnt_s   = HP_LOAD;
                    edge_cnt_s = 5'd0;
                    sck_s      = 1'b0;
                end else begin
                    setup_cnt_s = setup_cnt_r - 4'd1;
                end
            end
            ST_XFER: begin
                if (bus.Abort) begin
                    abort_s = 1'b1;
                    state_s = ST_DONE;
                    sck_s   = 1'b0;
                end else if (hp_cnt_r == 8'd0) begin
                    sck_s    = ~sck_r;
                    hp_cnt_s = HP_LOAD;
                    if (edge_cnt_r == XFER_LAST) begin
                        state_s    = ST_EOC;
                        edge_cnt_s = 5'd0;
                    end else begin
                        edge_cnt_s = edge_cnt_r + 5'd1;
                    end
                end else begin
                    hp_cnt_s = hp_cnt_r - 8'd1;
                end
            end
            ST_EOC: begin
                if (bus.Abort) begin
                    abort_s = 1'b1;
                    state_s = ST_DONE;
                    sck_s   = 1'b0;
                end else if (hp_cnt_r == 8'd0) begin
                    hp_cnt_s = HP_LOAD;
                    if (edge_cnt_r == EOC_LAST) begin
                        state_s    = ST_DONE;
                        capture_s  = 1'b1;
                        sck_s      = 1'b0;
                        edge_cnt_s = 5'd0;
                    end else begin
                        sck_s      = ~sck_r;
                        edge_cnt_s = edge_cnt_r + 5'd1;
                    end
                end else begin
                    hp_cnt_s = hp_cnt_r - 8'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                sck_s   = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                sck_s   = 1'b0;
            end
        endcase
    end

    // State, counters and bus controls; outputs are registered from the next state so they align with it.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r     <= ST_IDLE;
            hp_cnt_r    <= 8'd0;
            edge_cnt_r  <= 5'd0;
            setup_cnt_r <= 4'd0;
            sck_r       <= 1'b0;
            ssel_r      <= 1'b0;
            en_r        <= 1'b0;
            eoc_r       <= 1'b0;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_abort_r <= 1'b0;
            rsp_data_r  <= 12'd0;
        end else begin
            state_r     <= state_s;
            hp_cnt_r    <= hp_cnt_s;
            edge_cnt_r  <= edge_cnt_s;
            setup_cnt_r <= setup_cnt_s;
            sck_r       <= sck_s;
            ssel_r      <= (state_s == ST_SEL) || (state_s == ST_XFER) || (state_s == ST_EOC);
            en_r        <= (state_s == ST_XFER);
            eoc_r       <= (state_s == ST_EOC);
            ready_r     <= (state_s == ST_IDLE);
            rsp_valid_r <= (state_s == ST_DONE);
            rsp_abort_r <= abort_s;
            if (capture_s) begin
                rsp_data_r <= bus.SSP_DO;
            end
        end
    end

    // Command holding registers; they drive the slave address/data lines for the whole frame.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ra_r  <= 3'd0;
            wnr_r <= 1'b0;
            di_r  <= 12'd0;
        end else if (accept_s) begin
            ra_r  <= bus.Req_RA;
            wnr_r <= bus.Req_WnR;
            di_r  <= bus.Req_Data;
        end
    end

`ifdef SSP_UART_HOST_IRQ_SYNC_EN
    logic [1:0] irq_sync_r;

    // Two-flop synchronizer for an IRQ coming from another clock domain.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            irq_sync_r <= 2'b00;
        end else begin
            irq_sync_r <= {irq_sync_r[0], bus.IRQ};
        end
    end
    assign irq_set_s = irq_sync_r[1];
`else
    assign irq_set_s = bus.IRQ;
`endif

    // Sticky interrupt flag; a set in the same cycle as a clear wins.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            irq_pend_r <= 1'b0;
        end else begin
            irq_pend_r <= irq_set_s | (irq_pend_r & ~bus.Irq_Clr);
        end
    end

    assign bus.Req_Ready = ready_r;
    assign bus.Rsp_Valid = rsp_valid_r;
    assign bus.Rsp_Abort = rsp_abort_r;
    assign bus.Rsp_Data  = rsp_data_r;
    assign bus.SSP_SSEL  = ssel_r;
    assign bus.SSP_SCK   = sck_r;
    assign bus.SSP_En    = en_r;
    assign bus.SSP_EOC   = eoc_r;
    assign bus.SSP_RA    = ra_r;
    assign bus.SSP_WnR   = wnr_r;
    assign bus.SSP_DI    = di_r;
    assign bus.Irq_Pend  = irq_pend_r;

endmodule

// File: tb/tb_ssp_uart_host.sv
// Directed bench for ssp_uart_host: default instance (CLK_DIV=2, SETUP=1) and a fast one (CLK_DIV=1, SETUP=4).
module tb_ssp_uart_host;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ssp_uart_host_if aif ();
    ssp_uart_host_if bif ();

    ssp_uart_host #(.CLK_DIV(2), .SETUP(1)) dut_a (.Clk(clk), .Rst(rst_n), .bus(aif.master));
    ssp_uart_host #(.CLK_DIV(1), .SETUP(4)) dut_b (.Clk(clk), .Rst(rst_n), .bus(bif.master));

    // Frame observations on the default instance, indexed by cycles after the accept edge.
    int          m_ssel_at, m_ssel_last, m_en_at, m_eoc_at, m_eoc_len;
    int          m_rsp_at, m_rsp_cnt, m_sck_rises, m_bus_bad, m_xfer_n;
    logic        m_rsp_abort, m_ready_after, m_prev_sck;
    logic [11:0] m_rsp_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_a(input logic wnr, input logic [2:0] ra, input logic [11:0] data,
                           input logic [11:0] do_val, input int abort_at);
        aif.Req_RA    = ra;
        aif.Req_WnR   = wnr;
        aif.Req_Data  = data;
        aif.Req_Valid = 1'b1;
        tick();
        aif.Req_Valid = 1'b0;
        m_ssel_at = 0; m_ssel_last = 0; m_en_at = 0; m_eoc_at = 0; m_eoc_len = 0;
        m_rsp_at = 0; m_rsp_cnt = 0; m_sck_rises = 0; m_bus_bad = 0; m_xfer_n = 0;
        m_rsp_abort = 1'b0; m_ready_after = 1'b0; m_prev_sck = 1'b0; m_rsp_data = 12'd0;
        for (int n = 1; n <= 60; n++) begin
            if (aif.SSP_SSEL) begin
                if (m_ssel_at == 0) m_ssel_at = n;
                m_ssel_last = n;
                if (aif.SSP_DI !== data || aif.SSP_RA !== ra || aif.SSP_WnR !== wnr) m_bus_bad++;
            end
            if (aif.SSP_En) begin
                if (m_en_at == 0) m_en_at = n;
                m_xfer_n++;
            end
            if (aif.SSP_EOC) begin
                if (m_eoc_at == 0) m_eoc_at = n;
                m_eoc_len++;
            end
            if (aif.SSP_SCK && !m_prev_sck) m_sck_rises++;
            m_prev_sck = aif.SSP_SCK;
            if (aif.Rsp_Valid) begin
                if (m_rsp_at == 0) begin
                    m_rsp_at    = n;
                    m_rsp_abort = aif.Rsp_Abort;
                    m_rsp_data  = aif.Rsp_Data;
                end
                m_rsp_cnt++;
            end
            if (m_rsp_at != 0 && n == m_rsp_at + 1) m_ready_after = aif.Req_Ready;
            // Only the last EOC cycle carries the real read value.
            aif.SSP_DO = (aif.SSP_EOC && m_eoc_len == 4) ? do_val : 12'h0F0;
            aif.Abort  = (abort_at != 0 && aif.SSP_En && m_xfer_n == abort_at);
            tick();
        end
        aif.Abort = 1'b0;
    endtask

    initial begin
        int   b_ready_bad, b_rsp_at, b_ssel2_at, b_rsp_cnt, irq_first, rv_cnt;
        logic b_prev_ready, b_ready32;
        int   irq_lat;

        aif.Req_Valid = 1'b0; aif.Req_RA = 3'd0; aif.Req_WnR = 1'b0; aif.Req_Data = 12'd0;
        aif.Abort = 1'b0; aif.SSP_DO = 12'd0; aif.IRQ = 1'b0; aif.Irq_Clr = 1'b0;
        bif.Req_Valid = 1'b0; bif.Req_RA = 3'd0; bif.Req_WnR = 1'b0; bif.Req_Data = 12'd0;
        bif.Abort = 1'b0; bif.SSP_DO = 12'd0; bif.IRQ = 1'b0; bif.Irq_Clr = 1'b0;

        // Reset state.
        tick(); tick(); tick();
        check("rst_ready", 32'(aif.Req_Ready), 32'd1);
        check("rst_ssel", 32'(aif.SSP_SSEL), 32'd0);
        check("rst_di", 32'(aif.SSP_DI), 32'd0);
        check("rst_rsp_data", 32'(aif.Rsp_Data), 32'd0);
        check("rst_irq_pend", 32'(aif.Irq_Pend), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Write RA=1 Data=A5C; captured SSP_DO 5A1 lands in Rsp_Data.
        frame_a(1'b1, 3'd1, 12'hA5C, 12'h5A1, 0);
        check("wr_ssel_at", 32'(m_ssel_at), 32'd1);
        check("wr_en_at", 32'(m_en_at), 32'd2);
        check("wr_eoc_at", 32'(m_eoc_at), 32'd50);
        check("wr_eoc_len", 32'(m_eoc_len), 32'd4);
        check("wr_sck_rises", 32'(m_sck_rises), 32'd13);
        check("wr_rsp_at", 32'(m_rsp_at), 32'd54);
        check("wr_ssel_last", 32'(m_ssel_last), 32'd53);
        check("wr_rsp_cnt", 32'(m_rsp_cnt), 32'd1);
        check("wr_bus_stable", 32'(m_bus_bad), 32'd0);
        check("wr_rsp_abort", 32'(m_rsp_abort), 32'd0);
        check("wr_rsp_data", 32'(m_rsp_data), 32'h5A1);
        check("wr_ready_after", 32'(m_ready_after), 32'd1);

        // Read RA=2 returning 3C7.
        frame_a(1'b0, 3'd2, 12'h777, 12'h3C7, 0);
        check("rd_rsp_at", 32'(m_rsp_at), 32'd54);
        check("rd_bus_stable", 32'(m_bus_bad), 32'd0);
        check("rd_rsp_data", 32'(m_rsp_data), 32'h3C7);
        check("rd_rsp_abort", 32'(m_rsp_abort), 32'd0);

        // Abort in IDLE is ignored.
        aif.Abort = 1'b1;
        tick();
        aif.Abort = 1'b0;
        check("idle_abort_valid", 32'(aif.Rsp_Valid), 32'd0);
        check("idle_abort_ready", 32'(aif.Req_Ready), 32'd1);

        // Abort on the 5th XFER cycle.
        frame_a(1'b1, 3'd4, 12'h0FF, 12'hBAD, 5);
        check("ab_ssel_last", 32'(m_ssel_last), 32'd6);
        check("ab_rsp_at", 32'(m_rsp_at), 32'd7);
        check("ab_rsp_abort", 32'(m_rsp_abort), 32'd1);
        check("ab_rsp_data", 32'(m_rsp_data), 32'h3C7);
        check("ab_eoc_len", 32'(m_eoc_len), 32'd0);
        check("ab_rsp_cnt", 32'(m_rsp_cnt), 32'd1);

        // Fast instance: two back-to-back requests.
        bif.Req_RA = 3'd5; bif.Req_WnR = 1'b1; bif.Req_Data = 12'h123; bif.Req_Valid = 1'b1;
        tick();
        b_ready_bad = 0; b_rsp_at = 0; b_ssel2_at = 0; b_rsp_cnt = 0;
        b_prev_ready = 1'b0; b_ready32 = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            if (n <= 31 && bif.Req_Ready) b_ready_bad++;
            if (n == 32) b_ready32 = bif.Req_Ready;
            if (bif.Rsp_Valid) begin
                if (b_rsp_at == 0) b_rsp_at = n;
                b_rsp_cnt++;
            end
            if (b_rsp_at != 0 && n > b_rsp_at && bif.SSP_SSEL && b_ssel2_at == 0) b_ssel2_at = n;
            if (b_prev_ready) bif.Req_Valid = 1'b0;
            b_prev_ready = bif.Req_Ready;
            tick();
        end
        bif.Req_Valid = 1'b0;
        check("b2b_ready_low", 32'(b_ready_bad), 32'd0);
        check("b2b_rsp_at", 32'(b_rsp_at), 32'd31);
        check("b2b_ready_32", 32'(b_ready32), 32'd1);
        check("b2b_ssel2_at", 32'(b_ssel2_at), 32'd33);
        check("b2b_rsp_cnt", 32'(b_rsp_cnt), 32'd2);

        // Reset mid-XFER on both instances' shared reset.
        aif.Req_RA = 3'd3; aif.Req_WnR = 1'b1; aif.Req_Data = 12'hC3C; aif.Req_Valid = 1'b1;
        tick();
        aif.Req_Valid = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        check("mid_en_before", 32'(aif.SSP_En), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ssel", 32'(aif.SSP_SSEL), 32'd0);
        check("mid_rst_en", 32'(aif.SSP_En), 32'd0);
        check("mid_rst_sck", 32'(aif.SSP_SCK), 32'd0);
        check("mid_rst_di", 32'(aif.SSP_DI), 32'd0);
        check("mid_rst_ra", 32'(aif.SSP_RA), 32'd0);
        check("mid_rst_valid", 32'(aif.Rsp_Valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rv_cnt = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (aif.Rsp_Valid) rv_cnt++;
        end
        check("mid_no_rsp", 32'(rv_cnt), 32'd0);
        check("mid_ready_after", 32'(aif.Req_Ready), 32'd1);

        // IRQ pulse coincident with Irq_Clr: set wins.
`ifdef SSP_UART_HOST_IRQ_SYNC_EN
        irq_lat = 3;
`else
        irq_lat = 1;
`endif
        aif.IRQ = 1'b1;
        aif.Irq_Clr = 1'b1;
        tick();
        aif.IRQ = 1'b0;
        aif.Irq_Clr = 1'b0;
        irq_first = 0;
        for (int n = 1; n <= 4; n++) begin
            if (aif.Irq_Pend && irq_first == 0) irq_first = n;
            if (n < 4) tick();
        end
        check("irq_latency", 32'(irq_first), 32'(irq_lat));
        check("irq_sticky", 32'(aif.Irq_Pend), 32'd1);
        aif.Irq_Clr = 1'b1;
        tick();
        aif.Irq_Clr = 1'b0;
        check("irq_cleared", 32'(aif.Irq_Pend), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
